// File: rtl/run_ctrl_pkg.sv
// Shared types for the run sequencer: controller state encoding and
// program-select codes.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_INIT = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // ProgSel code 3 has no program of its own and falls back to program 0.
  localparam logic [1:0] SEL_PROG0     = 2'd0;
  localparam logic [1:0] SEL_PROG1     = 2'd1;
  localparam logic [1:0] SEL_PROG2     = 2'd2;
  localparam logic [1:0] SEL_PROG0_ALT = 2'd3;

endpackage

// File: rtl/run_ctrl_cycle_counter.sv
// Run-length counter: sync clear has priority over enable. The terminal
// flag marks the last cycle before the watchdog limit is reached.
module cycle_counter
  import run_ctrl_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 50000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: turns the Start/Ack handshake into preload hold, a one-cycle
// PC load and a gated run phase ended by Halt or the watchdog.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 50000,
  parameter int PROG0_ADDR = 0,
  parameter int PROG1_ADDR = 128,
  parameter int PROG2_ADDR = 256
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       ProgSel,
  input  logic             Halt,
  output logic             RunEn,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcStart,
  output logic             Ack,
  output logic             Timeout,
  output logic [CNT_W-1:0] CycleCount,
  output logic [2:0]       DbgState
);

  // Handshake: Start is a level, not a pulse. The bench holds it high for
  // the whole preload; its falling edge in HOLD launches the run, and a
  // rising level in DONE requests the next run (dropping Ack at once).
  state_e          state_q, state_d;
  logic            run_en_q, pc_load_q, ack_q, timeout_q, timeout_d;
  logic [PC_W-1:0] pc_start_q, pc_start_d, sel_addr;
  logic            cnt_clr, cnt_en, cnt_tc;

  always_comb begin
    case (ProgSel)
      SEL_PROG1: sel_addr = PC_W'(PROG1_ADDR);
      SEL_PROG2: sel_addr = PC_W'(PROG2_ADDR);
      default:   sel_addr = PC_W'(PROG0_ADDR);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    timeout_d  = timeout_q;
    pc_start_d = pc_start_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        pc_start_d = sel_addr;
        if (!Start) begin
          state_d   = ST_INIT;
          timeout_d = 1'b0;
          cnt_clr   = 1'b1;
        end
      end
      ST_INIT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_en = 1'b1;
        // Halt takes priority so a program finishing on the last allowed
        // cycle is not reported as a timeout.
        if (Halt) begin
          state_d = ST_DONE;
        end else if (cnt_tc) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (Start) state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      run_en_q   <= 1'b0;
      pc_load_q  <= 1'b0;
      ack_q      <= 1'b0;
      timeout_q  <= 1'b0;
      pc_start_q <= PC_W'(PROG0_ADDR);
    end else begin
      state_q    <= state_d;
      run_en_q   <= (state_d == ST_RUN);
      pc_load_q  <= (state_d == ST_INIT);
      ack_q      <= (state_d == ST_DONE);
      timeout_q  <= timeout_d;
      pc_start_q <= pc_start_d;
    end
  end

  cycle_counter #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cycle_counter (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (CycleCount),
    .tc_o    (cnt_tc)
  );

  assign RunEn    = run_en_q;
  assign PcLoad   = pc_load_q;
  assign PcStart  = pc_start_q;
  assign Ack      = ack_q;
  assign Timeout  = timeout_q;
  assign DbgState = state_q;

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Run sequencer for the CSE141L processor top level. It converts the bench-style Start/Ack handshake into core control signals:
- a memory-preload hold window,
- a one-cycle PC load of the selected program's entry address,
- a gated run phase ended by the decoder's Halt or by a watchdog.

It sits between the TopLevel ports and the PC/register-file/data-memory write enables. It replaces ad-hoc start/done logic.

Parameters:
PC_W, 10, program counter width
CNT_W, 16, cycle counter width; MAX_CYCLES < 2**CNT_W is required
MAX_CYCLES, 50000, watchdog limit in RUN cycles
PROG0_ADDR, 0, entry PC for ProgSel 0 (also used for ProgSel 3)
PROG1_ADDR, 128, entry PC for ProgSel 1
PROG2_ADDR, 256, entry PC for ProgSel 2

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high
Start  in  1  run request; held high during memory preload
ProgSel  in  2  program select, sampled every HOLD cycle
Halt  in  1  decoder flag: current instruction is the final one
RunEn  out  1  enables PC advance and RF/DM writes
PcLoad  out  1  one-cycle pulse: PC <= PcStart
PcStart  out  PC_W  entry address of the selected program
Ack  out  1  run complete (done flag)
Timeout  out  1  run ended by watchdog, not by Halt
CycleCount  out  CNT_W  number of RUN cycles in the last or current run

Behaviour:
- All outputs are registered (Moore). States: IDLE, HOLD, INIT, RUN, DONE.
- Reset, sampled at a rising edge (any state, including mid-RUN):
  - state IDLE
  - RunEn=0, PcLoad=0, Ack=0, Timeout=0, CycleCount=0, PcStart=PROG0_ADDR
- IDLE: Start=1 -> HOLD; otherwise stay. All enables 0.
- HOLD:
  - RunEn=0, so the core cannot disturb preloaded memory.
  - Each cycle, PcStart <= the address mapped from ProgSel.
  - Start=0 -> INIT.
- INIT (exactly one cycle):
  - PcLoad=1, CycleCount=0, Ack=0, Timeout=0.
  - -> RUN.
- RUN:
  - RunEn=1; CycleCount increments by 1 at the end of each RUN cycle.
  - Halt=1 -> DONE. The Halt cycle is the last RunEn cycle and is counted.
  - Else, if the cycle being completed is the MAX_CYCLES-th -> DONE with Timeout=1. RunEn is therefore high for at most MAX_CYCLES cycles.
  - Halt and watchdog expiry in the same cycle: Halt wins, Timeout=0.
  - Start is ignored.
- DONE:
  - Ack=1, RunEn=0.
  - Timeout, CycleCount and PcStart hold.
  - Start=1 -> HOLD; Ack is 0 from the first HOLD cycle.
- Halt is ignored outside RUN.
- Timing: Start sampled low in HOLD at edge k -> PcLoad high for cycle k..k+1 -> RunEn high from edge k+1.
- CycleCount never exceeds MAX_CYCLES, so no wrap is possible.

Decomposition:
- Package run_ctrl_pkg holds:
  - the state enum typedef (IDLE, HOLD, INIT, RUN, DONE)
  - ProgSel encoding constants
- One sub-module, cycle_counter: CNT_W-bit counter with sync clear, enable and terminal-count flag (count == MAX_CYCLES-1). Instantiated once for the watchdog/CycleCount.

Test Plan:
1. Reset; Start high 3 cycles with ProgSel=1, then low; Halt in the 10th RUN cycle -> exactly one PcLoad pulse with PcStart=128; RunEn high 10 cycles; Ack=1, CycleCount=10, Timeout=0.
2. MAX_CYCLES=20 override; Halt never asserted -> RunEn high exactly 20 cycles; Ack=1, Timeout=1, CycleCount=20.
3. MAX_CYCLES=20; Halt asserted in the 20th RUN cycle -> Ack=1, Timeout=0, CycleCount=20.
4. Three back-to-back runs with ProgSel=0, 1, 2 (Halt after 5, 7, 9 cycles) -> Ack falls the cycle after each Start; PcStart=0/128/256; CycleCount=5/7/9; never stale.
5. Reset asserted in RUN cycle 5 -> next cycle IDLE, RunEn=0, Ack=0, CycleCount=0. A subsequent Halt pulse in IDLE causes no state change.
6. Start pulsed during RUN, and ProgSel=3 on a later run -> the run is unaffected by the Start pulse; the later run gets PcStart=0.
